uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Controller that sequences and configures the uart_rx receiver and buffers its output. It generates the 16x oversample tick from a programmable divisor and drives parity_enable. Configuration changes are applied only after the serial line has been idle for a full frame. Received bytes and their error flags go into a small FIFO behind a valid/ready interface, with saturating error and overrun counters.

Parameters:
DATA_BITS, 8, width of received data word (matches uart_rx)
FIFO_DEPTH, 8, entries in receive FIFO (power of two, >=2)
DIV_WIDTH, 16, width of baud divisor
CNT_WIDTH, 8, width of each saturating error counter
RESET_DIV, 27, divisor active after reset (clk cycles per 16x tick)
IDLE_TICKS, (DATA_BITS+3)*16, consecutive high-line ticks required before applying new config

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_write  in  1  one-cycle strobe: latch cfg_divisor/cfg_parity_en as pending config
cfg_divisor  in  DIV_WIDTH  requested divisor
cfg_parity_en  in  1  requested parity enable
cfg_pending  out  1  high while a config is latched but not yet applied
cfg_applied  out  1  one-cycle pulse when pending config becomes active
rx_pin  in  1  serial line (same net feeding uart_rx), used for idle detection
tick_16x  out  1  oversample tick to uart_rx
parity_enable  out  1  active parity enable to uart_rx
rx_data  in  DATA_BITS  byte from uart_rx
rx_data_ready  in  1  one-cycle valid pulse from uart_rx
rx_parity_err  in  1  parity error flag, qualified by rx_data_ready
rx_frame_err  in  1  frame error flag, qualified by rx_data_ready
m_valid  out  1  FIFO non-empty
m_ready  in  1  downstream accepts head entry
m_data  out  DATA_BITS  head entry data
m_parity_err  out  1  head entry parity flag
m_frame_err  out  1  head entry frame flag
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
flush  in  1  empty FIFO
cnt_clear  in  1  zero all counters
parity_err_cnt  out  CNT_WIDTH  saturating count of pushed entries with parity error
frame_err_cnt  out  CNT_WIDTH  saturating count of pushed entries with frame error
overrun_cnt  out  CNT_WIDTH  saturating count of bytes dropped because FIFO was full

Behaviour:
- Reset (sync, active-high): active divisor=RESET_DIV, parity_enable=0, cfg_pending=0, cfg_applied=0, tick counter=0, tick_16x=0, FIFO empty (m_valid=0, fifo_level=0), all counters 0. m_data/flags are don't-care while m_valid=0. Reset mid-frame discards the FIFO and any pending config.
- Tick gen: counter runs 0..div-1; tick_16x=1 for one cycle when counter==div-1, then counter wraps to 0. div of 0 or 1: tick_16x=1 every cycle. On config apply, counter restarts at 0.
- Config FSM states RUN, PENDING.
  - RUN + cfg_write: latch pending values, idle_cnt=0, go to PENDING.
  - PENDING + cfg_write: overwrite pending values, idle_cnt=0, stay in PENDING.
  - PENDING, on each tick_16x: idle_cnt+1 if rx_pin=1, else idle_cnt=0.
  - PENDING, when idle_cnt reaches IDLE_TICKS (with no cfg_write that cycle): next cycle the divisor and parity_enable take pending values, cfg_applied pulses, go to RUN.
  - cfg_pending=1 exactly while in PENDING.
- FIFO push: rx_data_ready=1 pushes {rx_data, rx_parity_err, rx_frame_err}; m_valid is seen the following cycle (1-cycle latency).
- FIFO pop: m_valid&&m_ready; head advances next cycle. Head output is registered or FWFT, and is stable while m_valid=1 and m_ready=0.
- Full + push without pop: byte dropped, overrun_cnt+1, FIFO unchanged.
- Full + push with pop same cycle: both occur, level unchanged, no overrun.
- Pointer wrap: FIFO_DEPTH power of two; extra pointer bit distinguishes full from empty.
- flush: FIFO empty next cycle; a same-cycle push is discarded and not counted as overrun. Counters are unaffected.
- Counters saturate at all-ones. They increment on push only (dropped bytes do not update parity/frame counters). cnt_clear wins over a same-cycle increment.

Test Plan:
- Reset then idle, RESET_DIV=27 -> tick_16x pulses exactly every 27 clk, parity_enable=0, m_valid=0.
- Push 0xA5, 0x3C via rx_data_ready with m_ready=0 -> fifo_level=2; raise m_ready -> m_data 0xA5 then 0x3C; m_valid falls after second pop.
- Push 9 bytes with FIFO_DEPTH=8 and m_ready=0 -> level 8, overrun_cnt=1, 9th byte absent; full+push+pop same cycle -> level stays 8, overrun_cnt unchanged.
- cfg_write div=10, parity=1 with rx_pin toggling low every 100 ticks -> cfg_pending stays 1; hold rx_pin high 176 ticks -> cfg_applied pulse, ticks every 10 clk, parity_enable=1.
- Push 300 entries with parity_err=1 -> parity_err_cnt saturates at 255; cnt_clear in the same cycle as a push -> 0.
- Assert reset while cfg_pending=1 and FIFO holds 3 entries -> next cycle divisor=RESET_DIV, cfg_pending=0, fifo_level=0.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 16x tick generator, idle-gated configuration update and a
// receive FIFO with saturating error/overrun counters for the uart_rx core.
`timescale 1ns/1ps
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int RESET_DIV  = 27,
    parameter int IDLE_TICKS = (DATA_BITS + 3) * 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_write,
    input  logic [DIV_WIDTH-1:0]          cfg_divisor,
    input  logic                          cfg_parity_en,
    output logic                          cfg_pending,
    output logic                          cfg_applied,
    input  logic                          rx_pin,
    output logic                          tick_16x,
    output logic                          parity_enable,
    input  logic [DATA_BITS-1:0]          rx_data,
    input  logic                          rx_data_ready,
    input  logic                          rx_parity_err,
    input  logic                          rx_frame_err,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_parity_err,
    output logic                          m_frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          flush,
    input  logic                          cnt_clear,
    output logic [CNT_WIDTH-1:0]          parity_err_cnt,
    output logic [CNT_WIDTH-1:0]          frame_err_cnt,
    output logic [CNT_WIDTH-1:0]          overrun_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int IDLE_W = $clog2(IDLE_TICKS + 1);
    localparam logic [PTR_W:0]     FULL_LVL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [IDLE_W-1:0]  IDLE_DONE = IDLE_W'(IDLE_TICKS);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

    typedef enum logic {RUN, PENDING} cfg_state_t;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 parity_err;
        logic                 frame_err;
    } entry_t;

    cfg_state_t            state;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  pend_div;
    logic                  pend_parity;
    logic [DIV_WIDTH-1:0]  tick_cnt;
    logic [IDLE_W-1:0]     idle_cnt;
    logic                  apply;

    // Divisors of 0 and 1 both mean "tick every clock".
    assign tick_16x    = (div_q <= DIV_ONE) || (tick_cnt == div_q - DIV_ONE);
    assign apply       = (state == PENDING) && !cfg_write && (idle_cnt == IDLE_DONE);
    assign cfg_pending = (state == PENDING);

    // NOTE: sequential state is written with <= only, so every register sees
    // the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            div_q         <= DIV_WIDTH'(RESET_DIV);
            parity_enable <= 1'b0;
            pend_div      <= '0;
            pend_parity   <= 1'b0;
            idle_cnt      <= '0;
            tick_cnt      <= '0;
            cfg_applied   <= 1'b0;
        end else begin
            cfg_applied <= 1'b0;

            if (apply || tick_16x)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + DIV_ONE;

            if (cfg_write) begin
                pend_div    <= cfg_divisor;
                pend_parity <= cfg_parity_en;
                idle_cnt    <= '0;
                state       <= PENDING;
            end else if (apply) begin
                div_q         <= pend_div;
                parity_enable <= pend_parity;
                cfg_applied   <= 1'b1;
                state         <= RUN;
            end else if ((state == PENDING) && tick_16x) begin
                if (!rx_pin)
                    idle_cnt <= '0;
                else if (idle_cnt != IDLE_DONE)
                    idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    entry_t         mem [FIFO_DEPTH];
    entry_t         head;
    logic           full;
    logic           pop;
    logic           push;
    logic           overrun;

    assign fifo_level = wr_ptr - rd_ptr;
    assign m_valid    = (wr_ptr != rd_ptr);
    assign full       = (fifo_level == FULL_LVL);
    assign pop        = m_valid && m_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push       = rx_data_ready && !flush && (!full || pop);
    assign overrun    = rx_data_ready && !flush && full && !pop;

    assign head         = mem[rd_ptr[PTR_W-1:0]];
    assign m_data       = head.data;
    assign m_parity_err = head.parity_err;
    assign m_frame_err  = head.frame_err;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
        end
    end

    // NOTE: the storage array has no reset; its contents are only observed
    // once the pointers say an entry was written.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[PTR_W-1:0]] <= '{data: rx_data, parity_err: rx_parity_err,
                                        frame_err: rx_frame_err};
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            parity_err_cnt <= '0;
            frame_err_cnt  <= '0;
            overrun_cnt    <= '0;
        end else begin
            if (push && rx_parity_err)
                parity_err_cnt <= sat_inc(parity_err_cnt);
            if (push && rx_frame_err)
                frame_err_cnt <= sat_inc(frame_err_cnt);
            if (overrun)
                overrun_cnt <= sat_inc(overrun_cnt);
        end
    end

endmodule
